// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, accumulator load selects,
// ALU operations, sequencer states and the decoded-instruction bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] AC_HOLD = 2'd0;
    localparam logic [1:0] AC_ALU  = 2'd1;
    localparam logic [1:0] AC_FILE = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] ac_sel;
        logic [2:0] alu_op;
        logic       we;
        logic       jmp;
        logic       jz;
        logic       hlt;
    } dec_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Sequencer bus: run/ROM/flag inputs and the strobes and addresses it drives.
interface cpu_controller_if #(
    parameter int IW = 8,
    parameter int AW = 4
);
    logic          run;
    logic [IW-1:0] rom_data;
    logic          ac_zero;
    logic [AW-1:0] rom_addr;
    logic [AW-1:0] pc;
    logic [AW-1:0] file_addr;
    logic          file_we;
    logic [1:0]    ac_en;
    logic [2:0]    alu_op;
    logic          halted;

    modport master (
        input  run, rom_data, ac_zero,
        output rom_addr, pc, file_addr, file_we, ac_en, alu_op, halted
    );

    modport slave (
        output run, rom_data, ac_zero,
        input  rom_addr, pc, file_addr, file_we, ac_en, alu_op, halted
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational opcode decoder; undefined opcodes B-E fall through as NOP.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.ac_sel = AC_HOLD;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OP_LDA: dec.ac_sel = AC_FILE;
            OP_STA: dec.we     = 1'b1;
            OP_ADD: begin dec.ac_sel = AC_ALU; dec.alu_op = ALU_ADD; end
            OP_SUB: begin dec.ac_sel = AC_ALU; dec.alu_op = ALU_SUB; end
            OP_AND: begin dec.ac_sel = AC_ALU; dec.alu_op = ALU_AND; end
            OP_OR:  begin dec.ac_sel = AC_ALU; dec.alu_op = ALU_OR;  end
            OP_XOR: begin dec.ac_sel = AC_ALU; dec.alu_op = ALU_XOR; end
            OP_NOT: begin dec.ac_sel = AC_ALU; dec.alu_op = ALU_NOT; end
            OP_JMP: dec.jmp = 1'b1;
            OP_JZ:  dec.jz  = 1'b1;
            OP_HLT: dec.hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer: owns pc and ir, registers file_addr/alu_op
// in DECODE and fires the accumulator/file strobes for the single EXEC cycle.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int IW = 8,
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    cpu_controller_if.master bus
);

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [IW-1:0] ir, ir_nxt;
    logic [AW-1:0] file_addr;
    logic [2:0]    alu_op;
    logic          file_we;
    logic [1:0]    ac_en;
    dec_t          dec;

    instr_decoder u_dec (
        .opcode (ir[IW-1 -: 4]),
        .dec    (dec)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        file_we   = 1'b0;
        ac_en     = AC_HOLD;
        case (state)
            S_FETCH: begin
                if (bus.run) begin
                    ir_nxt    = bus.rom_data;
                    pc_nxt    = pc + 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                ac_en   = dec.ac_sel;
                file_we = dec.we;
                // pc already holds the incremented (wrapped) value; a taken jump overrides it
                if (dec.jmp || (dec.jz && bus.ac_zero))
                    pc_nxt = ir[AW-1:0];
                state_nxt = dec.hlt ? S_HALT : S_FETCH;
            end
            S_HALT: ;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            file_addr <= '0;
            alu_op    <= ALU_ADD;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            if (state == S_DECODE) begin
                file_addr <= ir[AW-1:0];
                alu_op    <= dec.alu_op;
            end
        end
    end

    assign bus.rom_addr  = pc;
    assign bus.pc        = pc;
    assign bus.file_addr = file_addr;
    assign bus.file_we   = file_we;
    assign bus.ac_en     = ac_en;
    assign bus.alu_op    = alu_op;
    assign bus.halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: expected bus snapshots are queued with the
// cycle they are due and compared when the run reaches that cycle.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_controller_if #(.IW(8), .AW(4)) bus ();
    cpu_controller #(.IW(8), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] rom [16];
    assign bus.rom_data = rom[bus.rom_addr];

    typedef struct packed {
        logic [3:0] ra;
        logic [3:0] pc;
        logic [3:0] fa;
        logic [2:0] op;
        logic [1:0] en;
        logic       we;
        logic       h;
    } obs_t;

    typedef struct {
        string tag;
        int    at;
        obs_t  o;
    } exp_t;

    obs_t obs;
    assign obs = {bus.rom_addr, bus.pc, bus.file_addr, bus.alu_op, bus.ac_en, bus.file_we, bus.halted};

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic obs_t mk(logic [3:0] pc, logic [3:0] fa, logic [2:0] op,
                                logic [1:0] en, logic we, logic h);
        return {pc, pc, fa, op, en, we, h};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("rom_addr=%0d pc=%0d file_addr=%0d alu_op=%0d ac_en=%0d file_we=%0b halted=%0b",
                         o.ra, o.pc, o.fa, o.op, o.en, o.we, o.h);
    endfunction

    task automatic push(input string tag, input int at, input obs_t o);
        exp_t e;
        e.tag = tag; e.at = at; e.o = o;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: got %s want %s", tag, fmt(o), fmt(e));
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) tick();
            check(e.tag, obs, e.o);
        end
    endtask

    // After this the bench sits at the negedge of cycle 1 (first FETCH).
    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            assert (!(bus.file_we && bus.ac_en != 2'd0) && bus.ac_en != 2'd3) else begin
                failures++;
                $error("FAIL invariant: got file_we=%0b ac_en=%0d want no overlap and ac_en!=3",
                       bus.file_we, bus.ac_en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.run = 1'b0;
        bus.ac_zero = 1'b0;
        clear_rom();

        // Reset values while rst is held low
        @(negedge clk);
        check("reset_state", obs, mk(0, 0, 0, 0, 0, 0));

        // Reset asserted in the EXEC cycle of STA kills the strobe immediately
        rom[0] = 8'h27;
        bus.run = 1'b1;
        do_reset();
        push("sta_exec_pre_rst", 3, mk(1, 7, 0, 0, 1, 0));
        drain();
        #1 rst = 1'b0;
        #1 check("rst_mid_exec", obs, mk(0, 0, 0, 0, 0, 0));
        bus.run = 1'b0;
        do_reset();
        push("fetch_after_rst", 3, mk(0, 0, 0, 0, 0, 0));
        drain();

        // LDA / ADD / STA / HLT program
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h36; rom[2] = 8'h27; rom[3] = 8'hF0;
        bus.run = 1'b1;
        do_reset();
        push("lda_exec",  3,  mk(1, 5, ALU_ADD, AC_FILE, 0, 0));
        push("add_exec",  6,  mk(2, 6, ALU_ADD, AC_ALU,  0, 0));
        push("sta_exec",  9,  mk(3, 7, ALU_ADD, AC_HOLD, 1, 0));
        push("hlt_exec",  12, mk(4, 0, ALU_ADD, AC_HOLD, 0, 0));
        push("halted",    13, mk(4, 0, ALU_ADD, AC_HOLD, 0, 1));
        push("halt_hold", 20, mk(4, 0, ALU_ADD, AC_HOLD, 0, 1));
        drain();
        bus.run = 1'b0;
        do_reset();
        push("rst_from_halt", 1, mk(0, 0, 0, 0, 0, 0));
        drain();

        // JZ at pc=1, taken and not taken
        clear_rom();
        rom[1] = 8'hA3;
        bus.run = 1'b1;
        bus.ac_zero = 1'b1;
        do_reset();
        push("jz_taken", 7, mk(3, 3, 0, 0, 0, 0));
        drain();
        bus.ac_zero = 1'b0;
        do_reset();
        push("jz_not_taken", 7, mk(2, 3, 0, 0, 0, 0));
        drain();

        // JMP to 15, then JMP 0 / NOP at pc=15 wrapping to 0
        clear_rom();
        rom[0] = 8'h9F; rom[15] = 8'h90;
        do_reset();
        push("jmp_to_15", 4, mk(15, 15, 0, 0, 0, 0));
        push("fetch_wrap", 5, mk(0, 15, 0, 0, 0, 0));
        push("jmp_at_15", 7, mk(0, 0, 0, 0, 0, 0));
        drain();
        rom[15] = 8'h00;
        do_reset();
        push("nop_wrap", 7, mk(0, 0, 0, 0, 0, 0));
        drain();

        // run drops mid-instruction, pause for 5 FETCH cycles, then resume
        clear_rom();
        rom[1] = 8'h12;
        do_reset();
        push("run_drop", 2, mk(1, 0, 0, 0, 0, 0));
        drain();
        bus.run = 1'b0;
        push("nop_completes", 3, mk(1, 0, 0, 0, 0, 0));
        push("paused_first",  4, mk(1, 0, 0, 0, 0, 0));
        push("paused_last",   8, mk(1, 0, 0, 0, 0, 0));
        drain();
        bus.run = 1'b1;
        push("resume_lda", 10, mk(2, 2, ALU_ADD, AC_FILE, 0, 0));
        drain();

        // Undefined opcodes B-E and the remaining ALU ops
        clear_rom();
        rom[0] = 8'hB1; rom[1] = 8'hC2; rom[2] = 8'hD3; rom[3] = 8'hE4;
        rom[4] = 8'h45; rom[5] = 8'h78; rom[6] = 8'h80; rom[7] = 8'h6A;
        rom[8] = 8'h5B;
        do_reset();
        push("op_b",   3,  mk(1, 1,  ALU_ADD, AC_HOLD, 0, 0));
        push("op_c",   6,  mk(2, 2,  ALU_ADD, AC_HOLD, 0, 0));
        push("op_d",   9,  mk(3, 3,  ALU_ADD, AC_HOLD, 0, 0));
        push("op_e",   12, mk(4, 4,  ALU_ADD, AC_HOLD, 0, 0));
        push("op_sub", 15, mk(5, 5,  ALU_SUB, AC_ALU,  0, 0));
        push("op_xor", 18, mk(6, 8,  ALU_XOR, AC_ALU,  0, 0));
        push("op_not", 21, mk(7, 0,  ALU_NOT, AC_ALU,  0, 0));
        push("op_or",  24, mk(8, 10, ALU_OR,  AC_ALU,  0, 0));
        push("op_and", 27, mk(9, 11, ALU_AND, AC_ALU,  0, 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
